// File: rtl/uart_dump_pkg.sv
// uart_dump_pkg: state encoding and byte-lane helpers shared by the dump sequencer
package uart_dump_pkg;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_WAIT = 3'd1;
   localparam logic [2:0] ST_SEND    = 3'd2;
   localparam logic [2:0] ST_WAIT_TX = 3'd3;
   localparam logic [2:0] ST_NEXT    = 3'd4;
   function automatic int bytes_of(input int data_w);
      return data_w / 8;
   endfunction
   // Maps the send-order index onto the physical byte lane of the word
   function automatic int byte_lane(input int idx, input int nbytes, input bit lsb_first);
      return lsb_first ? idx : nbytes - 1 - idx;
   endfunction
endpackage

// File: rtl/uart_dump_ctrl_ser.sv
// dump_byte_ser: holds the fetched word and steps through its bytes in send order
module dump_byte_ser
   import uart_dump_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr,
   input  logic              adv,
   input  logic [DATA_W-1:0] word_in,
   output logic [7:0]        byte_out,
   output logic              last
);
   localparam int BYTES = bytes_of(DATA_W);
   localparam int IW    = BYTES > 1 ? $clog2(BYTES) : 1;
   logic [DATA_W-1:0] word_q, word_d;
   logic [IW-1:0]     idx_q, idx_d;
   always_comb begin
      word_d = load ? word_in : word_q;
      idx_d  = clr ? '0 : adv ? idx_q + IW'(1) : idx_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end
   assign byte_out = word_q[8*byte_lane(int'(idx_q), BYTES, LSB_FIRST) +: 8];
   assign last     = int'(idx_q) == BYTES - 1;
endmodule

// File: rtl/uart_dump_ctrl.sv
// uart_dump_ctrl: reads a memory window and feeds it to a UART transmitter one byte per handshake
module uart_dump_ctrl
   import uart_dump_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 16,
   parameter int START_ADDR = 8,
   parameter int END_ADDR   = 11,
   parameter int MEM_LAT    = 1,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              tx_done,
   output logic              tx_en,
   output logic [7:0]        tx_data,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [ADDR_W+3:0] byte_cnt
);
   localparam int CW = ADDR_W + 4;
   if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_data_w
      $error("DATA_W must be a multiple of 8 and at least 8");
   end
   if (END_ADDR < START_ADDR) begin : g_bad_window
      $error("END_ADDR must not be below START_ADDR");
   end
   if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
      $error("MEM_LAT must be in 1..7");
   end
   logic [2:0]        st_q, st_d, lat_q, lat_d;
   logic              start_q, mem_rd_q, mem_rd_d, tx_en_q, tx_en_d, busy_q, busy_d;
   logic              done_q, done_d, aborted_q, aborted_d, pend_q, pend_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        tx_data_q, tx_data_d, ser_byte;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              load, clr, adv, last, ab_exit;
   dump_byte_ser #(.DATA_W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_ser (
      .clk(clk), .rst(rst), .load(load), .clr(clr), .adv(adv),
      .word_in(mem_rdata), .byte_out(ser_byte), .last(last)
   );
   always_comb begin
      st_d = st_q;
      lat_d = lat_q;
      mem_rd_d = 1'b0;
      addr_d = addr_q;
      tx_en_d = tx_en_q;
      tx_data_d = tx_data_q;
      busy_d = busy_q;
      done_d = 1'b0;
      aborted_d = 1'b0;
      cnt_d = cnt_q;
      pend_d = pend_q;
      load = 1'b0;
      clr = 1'b0;
      adv = 1'b0;
      ab_exit = 1'b0;
      case (st_q)
         ST_IDLE: if (start && !start_q && !abort) begin
            addr_d = ADDR_W'(START_ADDR);
            mem_rd_d = 1'b1;
            busy_d = 1'b1;
            cnt_d = '0;
            clr = 1'b1;
            lat_d = '0;
            pend_d = 1'b0;
            st_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: if (abort) ab_exit = 1'b1;
            else if (lat_q == 3'(MEM_LAT - 1)) begin
               load = 1'b1;
               st_d = ST_SEND;
            end else lat_d = lat_q + 3'd1;
         ST_SEND: if (abort) ab_exit = 1'b1;
            else begin
               tx_data_d = ser_byte;
               tx_en_d = 1'b1;
               st_d = ST_WAIT_TX;
            end
         // An abort here is remembered so the byte on the wire is never cut short
         ST_WAIT_TX: begin
            pend_d = pend_q | abort;
            if (tx_done) begin
               tx_en_d = 1'b0;
               cnt_d = cnt_q + CW'(1);
               if (abort || pend_q) ab_exit = 1'b1;
               else if (last) st_d = ST_NEXT;
               else begin
                  adv = 1'b1;
                  st_d = ST_SEND;
               end
            end
         end
         ST_NEXT: if (abort) ab_exit = 1'b1;
            else if (addr_q == ADDR_W'(END_ADDR)) begin
               done_d = 1'b1;
               busy_d = 1'b0;
               st_d = ST_IDLE;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
               clr = 1'b1;
               mem_rd_d = 1'b1;
               lat_d = '0;
               st_d = ST_RD_WAIT;
            end
         default: st_d = ST_IDLE;
      endcase
      if (ab_exit) begin
         st_d = ST_IDLE;
         tx_en_d = 1'b0;
         busy_d = 1'b0;
         aborted_d = 1'b1;
         pend_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q <= ST_IDLE;
         lat_q <= '0;
         start_q <= 1'b0;
         mem_rd_q <= 1'b0;
         addr_q <= '0;
         tx_en_q <= 1'b0;
         tx_data_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         aborted_q <= 1'b0;
         cnt_q <= '0;
         pend_q <= 1'b0;
      end else begin
         st_q <= st_d;
         lat_q <= lat_d;
         start_q <= start;
         mem_rd_q <= mem_rd_d;
         addr_q <= addr_d;
         tx_en_q <= tx_en_d;
         tx_data_q <= tx_data_d;
         busy_q <= busy_d;
         done_q <= done_d;
         aborted_q <= aborted_d;
         cnt_q <= cnt_d;
         pend_q <= pend_d;
      end
   end
   assign mem_rd   = mem_rd_q;
   assign mem_addr = addr_q;
   assign tx_en    = tx_en_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign aborted  = aborted_q;
   assign byte_cnt = cnt_q;
endmodule
